// File: rtl/cpu_control_sequencer.sv
// cpu_control_sequencer: multi-cycle fetch/decode/execute/writeback controller
// for the 16-bit CPU. It drives the program-counter controls, fetches over a
// req/ack handshake and strobes the ALU and register file. A fetch watchdog
// halts the core when instruction memory stops answering.
module cpu_control_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int INSTR_W     = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               zero_flag,
  input  logic               alu_done,
  output logic               pc_inc,
  output logic               jump,
  output logic [ADDR_W-1:0]  jump_adr,
  output logic               branch,
  output logic [ADDR_W-1:0]  branch_adr,
  output logic [INSTR_W-1:0] ir,
  output logic               alu_start,
  output logic               reg_we,
  output logic               halted,
  output logic               fault
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
  } state_t;

  // Last counter value still tolerated before the watchdog fires.
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t             r_state;
  state_t             w_next;
  logic               r_imem_req;
  logic               r_alu_start;
  logic               r_taken;
  logic               r_fault;
  logic [7:0]         r_cnt;
  logic [INSTR_W-1:0] r_ir;

  logic [3:0] w_op;
  logic       w_is_alu, w_is_ldi, w_is_jmp, w_is_beq, w_is_bne, w_is_halt;
  logic       w_ack_ok, w_timeout;
  logic       w_pc_inc, w_jump, w_branch, w_reg_we;

  // Opcode classification of the held instruction.
  assign w_op      = r_ir[INSTR_W-1 -: 4];
  assign w_is_alu  = (w_op >= 4'h1) && (w_op <= 4'h7);
  assign w_is_ldi  = (w_op == 4'h8);
  assign w_is_jmp  = (w_op == 4'h9);
  assign w_is_beq  = (w_op == 4'hA);
  assign w_is_bne  = (w_op == 4'hB);
  assign w_is_halt = (w_op == 4'hF);

  // An ack only counts while our request is actually on the bus.
  assign w_ack_ok  = r_imem_req & imem_ack;
  assign w_timeout = (r_state == S_FETCH) && !w_ack_ok && (r_cnt == TO_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Next-state selection and writeback strobes (PC controls are mutually exclusive).
  always_comb begin
    w_next   = r_state;
    w_pc_inc = 1'b0;
    w_jump   = 1'b0;
    w_branch = 1'b0;
    w_reg_we = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        if (w_ack_ok)       w_next = S_DECODE;
        else if (w_timeout) w_next = S_HALT;
      end
      S_DECODE: w_next = S_EXECUTE;
      S_EXECUTE: begin
        if (w_is_halt)                 w_next = S_HALT;
        else if (!w_is_alu || alu_done) w_next = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        w_next   = S_FETCH;
        w_reg_we = w_is_alu | w_is_ldi;
        w_jump   = w_is_jmp;
        w_branch = (w_is_beq | w_is_bne) & r_taken;
        w_pc_inc = !w_is_jmp && !((w_is_beq | w_is_bne) & r_taken);
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  // Fetch request, watchdog counter, instruction capture, ALU kick and branch decision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_imem_req  <= 1'b0;
      r_cnt       <= 8'd0;
      r_ir        <= '0;
      r_fault     <= 1'b0;
      r_alu_start <= 1'b0;
      r_taken     <= 1'b0;
    end else begin
      // Request rises one cycle after entering FETCH and falls after the ack.
      r_imem_req <= (r_state == S_FETCH) && (w_next == S_FETCH);
      if ((r_state == S_FETCH) && !w_ack_ok) r_cnt <= r_cnt + 8'd1;
      else                                   r_cnt <= 8'd0;
      if (w_ack_ok) r_ir <= imem_rdata;
      if (w_timeout) r_fault <= 1'b1;
      r_alu_start <= (r_state == S_DECODE) && w_is_alu;
      if (r_state == S_EXECUTE)
        r_taken <= (w_is_beq & zero_flag) | (w_is_bne & ~zero_flag);
    end
  end

  assign imem_req   = r_imem_req;
  assign ir         = r_ir;
  assign jump_adr   = r_ir[ADDR_W-1:0];
  assign branch_adr = r_ir[ADDR_W-1:0];
  assign alu_start  = r_alu_start;
  assign pc_inc     = w_pc_inc;
  assign jump       = w_jump;
  assign branch     = w_branch;
  assign reg_we     = w_reg_we;
  assign halted     = (r_state == S_HALT);
  assign fault      = r_fault;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Bench for cpu_control_sequencer: acts as instruction memory and ALU, and
// predicts each instruction's strobes and latency from its opcode.
module tb_cpu_control_sequencer;

  localparam int ADDR_W      = 8;
  localparam int INSTR_W     = 16;
  localparam int MEM_TIMEOUT = 15;

  logic               clk = 1'b0;
  logic               reset;
  logic               imem_req, imem_ack, zero_flag, alu_done;
  logic [INSTR_W-1:0] imem_rdata, ir;
  logic               pc_inc, jump, branch, alu_start, reg_we, halted, fault;
  logic [ADDR_W-1:0]  jump_adr, branch_adr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_control_sequencer #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .zero_flag(zero_flag), .alu_done(alu_done),
    .pc_inc(pc_inc), .jump(jump), .jump_adr(jump_adr),
    .branch(branch), .branch_adr(branch_adr), .ir(ir),
    .alu_start(alu_start), .reg_we(reg_we), .halted(halted), .fault(fault)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Hold reset for a few cycles, release just after a rising edge.
  task automatic do_reset();
    reset = 1'b0; imem_ack = 1'b0; alu_done = 1'b0; zero_flag = 1'b0; imem_rdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Run one non-HALT instruction from FETCH entry to writeback and compare against
  // the opcode-level expectation.
  task automatic run_instr(input logic [15:0] ins, input logic zf, input int ack_dly, input int alu_dly);
    logic [3:0]  op;
    bit          is_alu, exp_jump, exp_branch, exp_inc, exp_we;
    int          lat, n, rq, k, n_as, n_we;
    bit          acked, seen_as, done_wb, req_bad, overlap, got_inc, got_jump, got_branch;
    logic [15:0] ir_wb;
    logic [7:0]  ja, ba;
    op         = ins[15:12];
    is_alu     = (op >= 4'd1) && (op <= 4'd7);
    exp_jump   = (op == 4'd9);
    exp_branch = ((op == 4'd10) && zf) || ((op == 4'd11) && !zf);
    exp_inc    = !exp_jump && !exp_branch;
    exp_we     = is_alu || (op == 4'd8);
    lat        = 5 + ack_dly + (is_alu ? alu_dly : 0);
    n = 0; rq = 0; k = 0; n_as = 0; n_we = 0;
    acked = 0; seen_as = 0; done_wb = 0; req_bad = 0; overlap = 0;
    got_inc = 0; got_jump = 0; got_branch = 0; ir_wb = '0; ja = '0; ba = '0;
    zero_flag = zf;
    while (!done_wb && n < 80) begin
      @(negedge clk);
      n++;
      if (alu_start) begin n_as++; seen_as = 1; end
      if (reg_we) n_we++;
      if (int'(pc_inc) + int'(jump) + int'(branch) > 1) overlap = 1;
      if (acked && imem_req) req_bad = 1;
      if (pc_inc || jump || branch) begin
        done_wb = 1; got_inc = pc_inc; got_jump = jump; got_branch = branch;
        ir_wb = ir; ja = jump_adr; ba = branch_adr;
      end else begin
        if (!acked && imem_req) begin
          if (rq == ack_dly) begin imem_ack = 1'b1; imem_rdata = ins; acked = 1; end
          else begin imem_ack = 1'b0; imem_rdata = 16'($urandom); rq++; end
        end else if (acked) imem_ack = 1'($urandom);
        else imem_ack = 1'b0;
        if (is_alu) begin
          if (seen_as) begin alu_done = (k == alu_dly); k++; end
          else alu_done = 1'b0;
        end else alu_done = 1'($urandom);
      end
    end
    imem_ack = 1'b0; alu_done = 1'b0;
    check_val("wb_reached", done_wb, 1);
    check_val("latency", n, lat);
    check_val("alu_start_count", n_as, is_alu ? 1 : 0);
    check_val("reg_we_count", n_we, exp_we);
    check_val("jump", got_jump, exp_jump);
    check_val("branch", got_branch, exp_branch);
    check_val("pc_inc", got_inc, exp_inc);
    check_val("ir", ir_wb, ins);
    check_val("jump_adr", ja, ins[7:0]);
    check_val("branch_adr", ba, ins[7:0]);
    check_val("pc_ctl_overlap", overlap, 0);
    check_val("req_after_ack", req_bad, 0);
    check_val("halted_running", {halted, fault}, 2'b00);
  endtask

  // Fetch a HALT instruction, then confirm the core stays stopped whatever the inputs do.
  task automatic run_halt(input int ack_dly);
    int n, rq;
    bit acked, stray;
    n = 0; rq = 0; acked = 0; stray = 0;
    zero_flag = 1'($urandom);
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (pc_inc || jump || branch || reg_we || alu_start) stray = 1;
      if (halted) break;
      if (!acked && imem_req) begin
        if (rq == ack_dly) begin imem_ack = 1'b1; imem_rdata = 16'hF000; acked = 1; end
        else begin imem_ack = 1'b0; rq++; end
      end else imem_ack = 1'b0;
      alu_done = 1'($urandom);
    end
    check_val("halt_seen", halted, 1);
    check_val("halt_latency", n, 5 + ack_dly);
    check_val("halt_fault", fault, 0);
    repeat (8) begin
      imem_ack = 1'($urandom); alu_done = 1'($urandom); zero_flag = 1'($urandom);
      @(negedge clk);
      if (pc_inc || jump || branch || reg_we || alu_start || imem_req || !halted) stray = 1;
    end
    check_val("halt_absorbing", stray, 0);
    check_val("halt_still", {halted, fault}, 2'b10);
  endtask

  initial begin
    int n;
    logic [3:0] op;
    logic [15:0] ins;
    reset = 1'b0; imem_ack = 1'b0; alu_done = 1'b0; zero_flag = 1'b0; imem_rdata = '0;
    #1;
    check_val("reset_outputs",
      {imem_req, pc_inc, jump, branch, alu_start, reg_we, halted, fault, ir, jump_adr, branch_adr}, 0);
    do_reset();

    // Directed instructions with single-cycle acks.
    run_instr(16'h8305, 1'b0, 0, 0);
    run_instr(16'h9001, 1'b0, 0, 0);
    run_instr(16'hA080, 1'b1, 0, 0);
    run_instr(16'hA080, 1'b0, 0, 0);
    run_instr(16'hB0C3, 1'b0, 1, 0);
    run_instr(16'hB0C3, 1'b1, 0, 0);
    run_instr(16'h2120, 1'b0, 0, 4);
    run_instr(16'h7FFF, 1'b1, 2, 0);
    run_instr(16'h0000, 1'b0, 0, 0);
    run_instr(16'hC0AA, 1'b1, 3, 0);
    run_instr(16'hE055, 1'b0, 0, 0);

    // Random program, HALT excluded so the stream keeps running.
    for (int i = 0; i < 150; i++) begin
      op  = 4'($urandom_range(0, 14));
      ins = {op, 12'($urandom)};
      run_instr(ins, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 5));
    end

    // Asynchronous reset while a fetch request is outstanding.
    do_reset();
    @(negedge clk);
    @(negedge clk);
    check_val("req_before_reset", imem_req, 1);
    #2 reset = 1'b0;
    #1 check_val("async_reset_outputs",
      {imem_req, pc_inc, jump, branch, alu_start, reg_we, halted, fault, ir}, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    run_instr(16'h8305, 1'b0, 0, 0);

    // Memory never answers: watchdog fault.
    do_reset();
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (fault) break;
    end
    check_val("timeout_cycles", n, MEM_TIMEOUT + 1);
    check_val("timeout_state", {fault, halted, imem_req}, 3'b110);
    repeat (6) begin
      imem_ack = 1'b1; imem_rdata = 16'h8305;
      @(negedge clk);
    end
    check_val("fault_sticky", {fault, halted, reg_we, pc_inc}, 4'b1100);

    // Reset clears the fault; then HALT opcode stops the core without a fault.
    do_reset();
    #1 check_val("fault_cleared", {fault, halted}, 2'b00);
    run_instr(16'h3456, 1'b0, 1, 2);
    run_halt(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
